// File: rtl/rv_mem_arb_pkg.sv
// Shared types and defaults for the unified-memory arbiter.
//   t_arb_state : arbiter FSM states
//   t_mem_req   : fields presented on the memory port (we/be/addr/wdata)
//   fetch_req() : builds the memory request for an instruction fetch
package rv_mem_arb_pkg;

   localparam int DEF_STARVE_MAX = 4;
   localparam int DEF_CNT_W      = 3;

   typedef enum logic [2:0] {
      IDLE,
      REQ_I,
      REQ_D,
      WAIT_I,
      WAIT_D
   } t_arb_state;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } t_mem_req;

   // A fetch is always a full-word read.
   function automatic t_mem_req fetch_req(input logic [31:0] addr);
      t_mem_req r;
      r.we    = 1'b0;
      r.be    = 4'hF;
      r.addr  = addr;
      r.wdata = 32'h0;
      return r;
   endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Bundle of the fetch, load/store and memory-port signals of rv_mem_arb.
//   slave  : arbiter view (takes fetch/data requests and memory responses,
//            drives grants, response valids and the memory request)
//   master : environment view (fetch stage, LSU and memory together)
interface rv_mem_arb_if;

   logic        i_req;
   logic [31:0] i_addr;
   logic        i_flush;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;

   logic        d_req;
   logic        d_we;
   logic [3:0]  d_be;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        m_req;
   logic        m_we;
   logic [3:0]  m_be;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic        m_gnt;
   logic        m_rvalid;
   logic [31:0] m_rdata;

   modport slave (
      input  i_req, i_addr, i_flush,
      input  d_req, d_we, d_be, d_addr, d_wdata,
      input  m_gnt, m_rvalid, m_rdata,
      output i_gnt, i_rvalid, i_rdata,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, i_flush,
      output d_req, d_we, d_be, d_addr, d_wdata,
      output m_gnt, m_rvalid, m_rdata,
      input  i_gnt, i_rvalid, i_rdata,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_be, m_addr, m_wdata
   );

endinterface

// File: rtl/rv_mem_arb_pick.sv
// Winner select between fetch and data, plus the fetch starvation counter.
//   clk, rst        : clock, async active-high reset
//   i_req, i_flush  : fetch request and redirect
//   d_req           : data request
//   i_gnt, d_gnt    : grant pulses from the arbiter FSM
//   pick_i, pick_d  : one-hot winner (both 0 when nobody may win)
// CNT_W must satisfy 2**CNT_W > STARVE_MAX.
module rv_mem_arb_pick
   import rv_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic i_flush,
   input  logic d_req,
   input  logic i_gnt,
   input  logic d_gnt,
   output logic pick_i,
   output logic pick_d
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt;
   logic             i_cand;

   // A fetch raised together with a redirect targets a dead PC, so it may
   // not win this cycle.
   assign i_cand = i_req & ~i_flush;

   always_comb begin
      pick_d = d_req & (~i_cand | (starve_cnt < CNT_MAX));
      pick_i = i_cand & ~pick_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (i_gnt || !i_req) begin
         starve_cnt <= '0;
      end else if (d_gnt && (starve_cnt != CNT_MAX)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/rv_mem_arb.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction outstanding at a time; data has priority, bounded by the
// fetch starvation counter. A redirect kills an in-flight fetch response.
//   clk, rst : clock, async active-high reset
//   bus      : rv_mem_arb_if.slave (fetch, data and memory-port signals)
//
// state  | meaning
// IDLE   | nothing outstanding, arbitrating every cycle
// REQ_I  | fetch presented on m_*, waiting for m_gnt
// REQ_D  | data access presented on m_*, waiting for m_gnt
// WAIT_I | fetch accepted, waiting for m_rvalid
// WAIT_D | data access accepted, waiting for m_rvalid
module rv_mem_arb
   import rv_mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = DEF_STARVE_MAX,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic          clk,
   input  logic          rst,
   rv_mem_arb_if.slave   bus
);

   t_arb_state state_q, state_d;
   t_mem_req   mreq_q, mreq_d;
   logic       kill_q, kill_d;
   logic       pick_i, pick_d;
   logic       arb_en;
   logic       i_gnt_c, d_gnt_c;

   rv_mem_arb_pick #(
      .STARVE_MAX (STARVE_MAX),
      .CNT_W      (CNT_W)
   ) u_pick (
      .clk     (clk),
      .rst     (rst),
      .i_req   (bus.i_req),
      .i_flush (bus.i_flush),
      .d_req   (bus.d_req),
      .i_gnt   (i_gnt_c),
      .d_gnt   (d_gnt_c),
      .pick_i  (pick_i),
      .pick_d  (pick_d)
   );

   // Re-arbitrating on the response cycle gives back-to-back issue.
   assign arb_en = (state_q == IDLE) ||
                   (((state_q == WAIT_I) || (state_q == WAIT_D)) && bus.m_rvalid);

   always_comb begin
      state_d  = state_q;
      mreq_d   = mreq_q;
      kill_d   = kill_q;
      i_gnt_c  = 1'b0;
      d_gnt_c  = 1'b0;
      bus.i_rvalid = 1'b0;
      bus.d_rvalid = 1'b0;

      case (state_q)
         REQ_I: begin
            // The memory request is never withdrawn; the response is
            // swallowed later instead.
            if (bus.i_flush) kill_d = 1'b1;
            if (bus.m_gnt) begin
               i_gnt_c = 1'b1;
               state_d = WAIT_I;
            end
         end
         REQ_D: begin
            if (bus.m_gnt) begin
               d_gnt_c = 1'b1;
               state_d = WAIT_D;
            end
         end
         WAIT_I: begin
            if (bus.m_rvalid) begin
               bus.i_rvalid = ~kill_q & ~bus.i_flush;
               kill_d       = 1'b0;
            end else if (bus.i_flush) begin
               kill_d = 1'b1;
            end
         end
         WAIT_D: begin
            if (bus.m_rvalid) bus.d_rvalid = 1'b1;
         end
         default: ;
      endcase

      if (arb_en) begin
         if (pick_d) begin
            state_d = REQ_D;
            mreq_d  = '{we: bus.d_we, be: bus.d_be, addr: bus.d_addr, wdata: bus.d_wdata};
         end else if (pick_i) begin
            state_d = REQ_I;
            mreq_d  = fetch_req(bus.i_addr);
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mreq_q  <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mreq_q  <= mreq_d;
         kill_q  <= kill_d;
      end
   end

   assign bus.i_gnt   = i_gnt_c;
   assign bus.d_gnt   = d_gnt_c;
   assign bus.m_req   = (state_q == REQ_I) || (state_q == REQ_D);
   assign bus.m_we    = mreq_q.we;
   assign bus.m_be    = mreq_q.be;
   assign bus.m_addr  = mreq_q.addr;
   assign bus.m_wdata = mreq_q.wdata;
   assign bus.i_rdata = bus.m_rdata;
   assign bus.d_rdata = bus.m_rdata;

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Shares a single unified memory port between instruction fetch and load/store data access.
- One transaction is outstanding at a time.
- Data requests have priority; a starvation counter bounds how long fetch can wait.
- A fetch flush (branch redirect) discards an in-flight instruction response, so the next PC's fetch never receives stale data.

Parameters:
- STARVE_MAX, 4: maximum consecutive data grants while i_req is pending before fetch is forced to win.
- CNT_W, 3: starvation counter width; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  fetch request; held with i_addr until i_gnt
- i_addr  in  32  fetch address (word-aligned PC)
- i_flush  in  1  branch redirect; kills the outstanding fetch
- i_gnt  out  1  fetch accepted by memory (1-cycle pulse)
- i_rvalid  out  1  fetch data valid (1-cycle pulse)
- i_rdata  out  32  fetch data, equal to m_rdata
- d_req  in  1  data request; held with d_we, d_be, d_addr, d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_be  in  4  byte enables
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_gnt  out  1  data accepted by memory (1-cycle pulse)
- d_rvalid  out  1  load data / store ack valid (1-cycle pulse)
- d_rdata  out  32  load data, equal to m_rdata
- m_req  out  1  memory request; held until m_gnt
- m_we  out  1  registered
- m_be  out  4  registered
- m_addr  out  32  registered
- m_wdata  out  32  registered
- m_gnt  in  1  memory accepted request
- m_rvalid  in  1  memory response; one per accepted request, including stores
- m_rdata  in  32  memory read data

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - m_req, m_we, m_be, m_addr, m_wdata go to 0.
  - Starvation counter goes to 0; kill flag goes to 0.
  - i_gnt, d_gnt, i_rvalid, d_rvalid are 0.
  - Reset mid-transaction abandons the transaction; any later m_rvalid is ignored until a new grant.
- States: IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D.
- Arbitration runs in IDLE, and in WAIT_x on the cycle m_rvalid=1 (back-to-back, no bubble).
  - Winner is D if d_req=1 and (i_req=0 or starve_cnt < STARVE_MAX); otherwise I if i_req=1.
  - Winner's fields are registered onto m_* and the FSM moves to REQ_I or REQ_D.
  - For a fetch: m_we=0, m_be=4'hF, m_wdata=0.
  - With no requester, the FSM goes to (or stays in) IDLE and m_req=0.
- REQ_x:
  - m_req=1 and m_* stay stable.
  - On m_gnt=1, pulse i_gnt or d_gnt combinationally in the same cycle, then move to WAIT_x.
- WAIT_x:
  - m_req=0.
  - On m_rvalid=1, pulse i_rvalid or d_rvalid in the same cycle (pass-through), then re-arbitrate.
- Latency:
  - Minimum request-to-data is 3 cycles (IDLE latch, REQ with immediate m_gnt, WAIT with m_rvalid the next cycle).
  - Back-to-back throughput is 1 transaction per 2 cycles.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each D grant while i_req=1.
  - Clears on an I grant or any cycle with i_req=0.
- Flush:
  - i_flush=1 in REQ_I or WAIT_I sets kill.
  - m_req is not withdrawn; the memory request must complete.
  - i_gnt is still pulsed, so the requester's hold releases.
  - The matching m_rvalid is consumed with i_rvalid held at 0; kill then clears.
  - i_flush in the same cycle as the m_rvalid of the fetch also suppresses i_rvalid.
  - i_flush in IDLE/REQ_D/WAIT_D has no effect; fetch simply re-requests the new PC.
  - i_flush on the same cycle I would win arbitration is suppressed: I does not win, and D or IDLE is chosen.
- Protocol robustness:
  - m_gnt outside REQ_x is ignored.
  - m_rvalid outside WAIT_x is ignored.
  - A requester dropping req before its grant is a protocol violation; the bench asserts against it.
- The data path never stalls on fetch; the fetch stage uses i_gnt/i_rvalid to drive its ready signals.

Decomposition:
- pkg gets:
  - t_arb_state enum (IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D).
  - t_mem_req struct (we, be, addr, wdata).
  - STARVE_MAX default constant.
- Optional sub-module rv_arb_pick: combinational winner select plus the starvation counter register.
- FSM and m_* registers stay in rv_mem_arb, using DFF macros with async reset.

Test Plan:
- Lone fetch, i_addr=0x100, m_gnt immediate, m_rdata=0x00500093 one cycle later:
  - Expect m_req at cycle 1 with m_addr=0x100, m_be=F.
  - Expect i_gnt at cycle 1 and i_rvalid with i_rdata=0x00500093 at cycle 2.
- Simultaneous i_req (0x104) and d_req store (0x2000, wdata 0xDEADBEEF, be=0x3):
  - D is served first with m_we=1, m_be=3.
  - After its m_rvalid, I is issued directly with no IDLE cycle.
- Continuous d_req plus continuous i_req, STARVE_MAX=4:
  - Exactly 4 D grants, then 1 I grant, pattern repeats.
  - Counter never exceeds 4.
- Fetch 0x108 with m_gnt delayed 3 cycles:
  - m_req and m_addr are stable for all 4 cycles.
  - i_gnt pulses once, on the m_gnt cycle.
- i_flush during WAIT_I, with the fetch m_rvalid arriving 2 cycles later:
  - i_rvalid stays 0.
  - The next fetch (0x200) is issued and returns normally with i_rvalid=1.
- rst asserted in WAIT_D, and a stray m_rvalid arrives after release:
  - All outputs are 0 asynchronously.
  - No d_rvalid; FSM is in IDLE.
  - A fresh d_req is granted normally.
